// File: rtl/id_stage_pipe_pkg.sv
// Shared constants for the ID stage: opcodes, funct3 codes, ALU operations,
// load/store width masks, forwarding selects and hazard-cause codes.
// No ports; imported by id_stage_pipe and id_stage_pipe_decode.
package id_stage_pipe_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_BYPASS = 4'd10;  // result = idex_imm

    localparam logic [1:0] MASK_B = 2'd0;
    localparam logic [1:0] MASK_H = 2'd1;
    localparam logic [1:0] MASK_W = 2'd2;

    typedef enum logic [1:0] {
        FORWARD_NONE = 2'd0,
        FORWARD_MEM  = 2'd1,
        FORWARD_WB   = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HZ_NONE     = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_BR_EX    = 2'd2,
        HZ_BR_LOAD  = 2'd3
    } hz_cause_e;

    // funct3 -> ALU op for OP/OP-IMM; alt selects SUB/SRA.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_f3 = ALU_SLL;
            3'b010:  alu_from_f3 = ALU_SLT;
            3'b011:  alu_from_f3 = ALU_SLTU;
            3'b100:  alu_from_f3 = ALU_XOR;
            3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_pipe_decode.sv
// Combinational RV32I decoder for the ID stage.
// In : pc, inst, rs1_val/rs2_val (already forwarded operands)
// Out: register fields + read enables, final ID/EX immediate, control bits,
//      illegal flag, is_br (branch/JALR reads operands in ID), taken, target.
module id_stage_pipe_decode
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [XLEN-1:0]   pc,
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    output logic              rs1_en,
    output logic              rs2_en,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    output logic [REG_AW-1:0] rd_addr,
    output logic [XLEN-1:0]   imm,
    output logic [3:0]        alu_op,
    output logic              alu_src,
    output logic              mem_read,
    output logic              mem_write,
    output logic              unsigned_load,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic [1:0]        mask,
    output logic              illegal,
    output logic              is_br,
    output logic              taken,
    output logic [XLEN-1:0]   target
);

    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, jalr_sum;
    logic            eq, lt, ltu;

    assign opcode   = inst[6:0];
    assign f3       = inst[14:12];
    assign f7       = inst[31:25];
    assign rs1_addr = REG_AW'(inst[19:15]);
    assign rs2_addr = REG_AW'(inst[24:20]);
    assign rd_addr  = REG_AW'(inst[11:7]);

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    assign jalr_sum = rs1_val + imm_i;
    assign eq       = (rs1_val == rs2_val);
    assign lt       = ($signed(rs1_val) < $signed(rs2_val));
    assign ltu      = (rs1_val < rs2_val);

    always_comb begin
        rs1_en        = 1'b0;
        rs2_en        = 1'b0;
        imm           = '0;
        alu_op        = ALU_ADD;
        alu_src       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        unsigned_load = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        mask          = MASK_W;
        illegal       = 1'b0;
        is_br         = 1'b0;
        taken         = 1'b0;
        target        = pc + imm_b;
        case (opcode)
            OP_LUI: begin
                imm = imm_u; alu_op = ALU_BYPASS; alu_src = 1'b1; reg_write = 1'b1;
            end
            OP_AUIPC: begin
                imm = pc + imm_u; alu_op = ALU_BYPASS; alu_src = 1'b1; reg_write = 1'b1;
            end
            OP_JAL: begin
                imm = pc + XLEN'(4); alu_op = ALU_BYPASS; alu_src = 1'b1; reg_write = 1'b1;
                taken = 1'b1; target = pc + imm_j;
            end
            OP_JALR: begin
                rs1_en = 1'b1; is_br = 1'b1;
                imm = pc + XLEN'(4); alu_op = ALU_BYPASS; alu_src = 1'b1; reg_write = 1'b1;
                taken = 1'b1; target = {jalr_sum[XLEN-1:1], 1'b0};
                illegal = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                rs1_en = 1'b1; rs2_en = 1'b1; is_br = 1'b1; imm = imm_b;
                case (f3)
                    F3_BEQ:  taken = eq;
                    F3_BNE:  taken = !eq;
                    F3_BLT:  taken = lt;
                    F3_BGE:  taken = !lt;
                    F3_BLTU: taken = ltu;
                    F3_BGEU: taken = !ltu;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                rs1_en = 1'b1; imm = imm_i; alu_src = 1'b1;
                mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
                mask = f3[1:0]; unsigned_load = f3[2];
                illegal = (f3[1:0] == 2'b11) || (f3[2] && f3[1]);
            end
            OP_STORE: begin
                rs1_en = 1'b1; rs2_en = 1'b1; imm = imm_s; alu_src = 1'b1;
                mem_write = 1'b1; mask = f3[1:0];
                illegal = f3[2] || (f3[1:0] == 2'b11);
            end
            OP_IMM: begin
                rs1_en = 1'b1; imm = imm_i; alu_src = 1'b1; reg_write = 1'b1;
                alu_op = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
                illegal = ((f3 == 3'b001) && (f7 != F7_BASE)) ||
                          ((f3 == 3'b101) && (f7 != F7_BASE) && (f7 != F7_ALT));
            end
            OP_OP: begin
                rs1_en = 1'b1; rs2_en = 1'b1; reg_write = 1'b1;
                alu_op = alu_from_f3(f3, f7[5]);
                illegal = !((f7 == F7_BASE) ||
                            ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            default: illegal = 1'b1;
        endcase
        // An undecodable word travels down as a NOP: no reads, writes or redirect.
        if (illegal) begin
            rs1_en = 1'b0; rs2_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            reg_write = 1'b0; mem_to_reg = 1'b0; is_br = 1'b0; taken = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// ID stage of the 5-stage RV32I pipeline: decode, operand forwarding from
// MEM/WB, hazard detection, early branch resolution, ID/EX register and
// saturating stall/redirect counters.
// Ports: IF/ID input (if_valid/if_pc/if_inst, id_ready), regfile read port,
// EX/MEM/WB producer info for forwarding and hazards, ex_ready back-pressure,
// redirect to IF, registered idex_* outputs, stall_cnt/redirect_cnt.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 16,
    parameter int BR_EX_STALL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [31:0]       if_inst,
    output logic              id_ready,
    output logic              rs1_rd_en,
    output logic              rs2_rd_en,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data_reg,
    input  logic [XLEN-1:0]   rs2_data_reg,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_fwd_data,
    input  logic              ex_ready,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              idex_valid,
    output logic [XLEN-1:0]   idex_pc,
    output logic [XLEN-1:0]   idex_imm,
    output logic [XLEN-1:0]   idex_rs1_data,
    output logic [XLEN-1:0]   idex_rs2_data,
    output logic [REG_AW-1:0] idex_rs1_addr,
    output logic [REG_AW-1:0] idex_rs2_addr,
    output logic [REG_AW-1:0] idex_rd_addr,
    output logic [3:0]        idex_alu_op,
    output logic              idex_alu_src,
    output logic              idex_mem_read,
    output logic              idex_mem_write,
    output logic              idex_unsigned_load,
    output logic              idex_reg_write,
    output logic              idex_mem_to_reg,
    output logic [1:0]        idex_mask,
    output logic              idex_illegal,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  redirect_cnt
);

    logic              rs1_en, rs2_en, dec_alu_src, dec_mem_read, dec_mem_write;
    logic              dec_unsigned, dec_reg_write, dec_mem_to_reg, dec_illegal;
    logic              is_br, br_taken;
    logic [REG_AW-1:0] dec_rd;
    logic [XLEN-1:0]   dec_imm, rs1_val, rs2_val;
    logic [3:0]        dec_alu_op;
    logic [1:0]        dec_mask;

    id_stage_pipe_decode #(.XLEN(XLEN), .REG_AW(REG_AW)) u_decode (
        .pc            (if_pc),
        .inst          (if_inst),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .rs1_en        (rs1_en),
        .rs2_en        (rs2_en),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rd_addr       (dec_rd),
        .imm           (dec_imm),
        .alu_op        (dec_alu_op),
        .alu_src       (dec_alu_src),
        .mem_read      (dec_mem_read),
        .mem_write     (dec_mem_write),
        .unsigned_load (dec_unsigned),
        .reg_write     (dec_reg_write),
        .mem_to_reg    (dec_mem_to_reg),
        .mask          (dec_mask),
        .illegal       (dec_illegal),
        .is_br         (is_br),
        .taken         (br_taken),
        .target        (redirect_pc)
    );

    assign rs1_rd_en = if_valid && rs1_en;
    assign rs2_rd_en = if_valid && rs2_en;

    // x0 is never a real dependency.
    logic src1_used, src2_used;
    assign src1_used = rs1_rd_en && (rs1_addr != '0);
    assign src2_used = rs2_rd_en && (rs2_addr != '0);

    // A load in MEM has no data yet, so it is skipped here (rule c stalls branches).
    fwd_sel_e fwd1, fwd2;
    always_comb begin
        fwd1 = FORWARD_NONE;
        fwd2 = FORWARD_NONE;
        if (src1_used && mem_reg_write && !mem_mem_read && (mem_rd_addr == rs1_addr))
            fwd1 = FORWARD_MEM;
        else if (src1_used && wb_reg_write && (wb_rd_addr == rs1_addr))
            fwd1 = FORWARD_WB;
        if (src2_used && mem_reg_write && !mem_mem_read && (mem_rd_addr == rs2_addr))
            fwd2 = FORWARD_MEM;
        else if (src2_used && wb_reg_write && (wb_rd_addr == rs2_addr))
            fwd2 = FORWARD_WB;
    end

    always_comb begin
        case (fwd1)
            FORWARD_MEM: rs1_val = mem_fwd_data;
            FORWARD_WB:  rs1_val = wb_fwd_data;
            default:     rs1_val = rs1_data_reg;
        endcase
        case (fwd2)
            FORWARD_MEM: rs2_val = mem_fwd_data;
            FORWARD_WB:  rs2_val = wb_fwd_data;
            default:     rs2_val = rs2_data_reg;
        endcase
    end

    logic      ex_match, mem_match, hazard, advance;
    hz_cause_e hz_cause;
    assign ex_match  = (src1_used && (rs1_addr == ex_rd_addr)) ||
                       (src2_used && (rs2_addr == ex_rd_addr));
    assign mem_match = (src1_used && (rs1_addr == mem_rd_addr)) ||
                       (src2_used && (rs2_addr == mem_rd_addr));

    // src*_used already carries if_valid, so an empty IF/ID never stalls.
    always_comb begin
        hz_cause = HZ_NONE;
        if (ex_match && ex_mem_read && ex_reg_write)
            hz_cause = HZ_LOAD_USE;
        else if ((BR_EX_STALL != 0) && is_br && ex_match && ex_reg_write)
            hz_cause = HZ_BR_EX;
        else if (is_br && mem_match && mem_mem_read)
            hz_cause = HZ_BR_LOAD;
    end

    assign hazard         = (hz_cause != HZ_NONE);
    assign id_ready       = !hazard && ex_ready;
    assign advance        = if_valid && id_ready;
    assign redirect_valid = advance && br_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_valid <= 1'b0; idex_pc <= '0; idex_imm <= '0;
            idex_rs1_data <= '0; idex_rs2_data <= '0;
            idex_rs1_addr <= '0; idex_rs2_addr <= '0; idex_rd_addr <= '0;
            idex_alu_op <= ALU_ADD; idex_alu_src <= 1'b0; idex_mem_read <= 1'b0;
            idex_mem_write <= 1'b0; idex_unsigned_load <= 1'b0; idex_reg_write <= 1'b0;
            idex_mem_to_reg <= 1'b0; idex_mask <= MASK_W; idex_illegal <= 1'b0;
        end else if (ex_ready) begin
            if (advance) begin
                idex_valid <= 1'b1; idex_pc <= if_pc; idex_imm <= dec_imm;
                idex_rs1_data <= rs1_val; idex_rs2_data <= rs2_val;
                idex_rs1_addr <= rs1_addr; idex_rs2_addr <= rs2_addr; idex_rd_addr <= dec_rd;
                idex_alu_op <= dec_alu_op; idex_alu_src <= dec_alu_src;
                idex_mem_read <= dec_mem_read; idex_mem_write <= dec_mem_write;
                idex_unsigned_load <= dec_unsigned; idex_reg_write <= dec_reg_write;
                idex_mem_to_reg <= dec_mem_to_reg; idex_mask <= dec_mask;
                idex_illegal <= dec_illegal;
            end else begin
                // Bubble: same contents as after reset.
                idex_valid <= 1'b0; idex_pc <= '0; idex_imm <= '0;
                idex_rs1_data <= '0; idex_rs2_data <= '0;
                idex_rs1_addr <= '0; idex_rs2_addr <= '0; idex_rd_addr <= '0;
                idex_alu_op <= ALU_ADD; idex_alu_src <= 1'b0; idex_mem_read <= 1'b0;
                idex_mem_write <= 1'b0; idex_unsigned_load <= 1'b0; idex_reg_write <= 1'b0;
                idex_mem_to_reg <= 1'b0; idex_mask <= MASK_W; idex_illegal <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (hazard && ex_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect_valid && (redirect_cnt != '1))
                redirect_cnt <= redirect_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a table of single-instruction vectors
// with an idle pipeline, then hand-written multi-cycle hazard, forwarding,
// back-pressure, reset and counter-saturation sequences.
module tb_id_stage_pipe;

    localparam int XLEN = 32, REG_AW = 5, CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0] if_inst;
    logic id_ready, rs1_rd_en, rs2_rd_en;
    logic [REG_AW-1:0] rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data_reg, rs2_data_reg;
    logic [REG_AW-1:0] ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write;
    logic [XLEN-1:0] mem_fwd_data, wb_fwd_data;
    logic ex_ready;
    logic redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic idex_valid;
    logic [XLEN-1:0] idex_pc, idex_imm, idex_rs1_data, idex_rs2_data;
    logic [REG_AW-1:0] idex_rs1_addr, idex_rs2_addr, idex_rd_addr;
    logic [3:0] idex_alu_op;
    logic idex_alu_src, idex_mem_read, idex_mem_write, idex_unsigned_load;
    logic idex_reg_write, idex_mem_to_reg, idex_illegal;
    logic [1:0] idex_mask;
    logic [CNT_W-1:0] stall_cnt, redirect_cnt;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W), .BR_EX_STALL(1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .id_ready(id_ready), .rs1_rd_en(rs1_rd_en), .rs2_rd_en(rs2_rd_en),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data_reg(rs1_data_reg), .rs2_data_reg(rs2_data_reg),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_fwd_data(mem_fwd_data), .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .wb_fwd_data(wb_fwd_data), .ex_ready(ex_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_imm(idex_imm),
        .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data),
        .idex_rs1_addr(idex_rs1_addr), .idex_rs2_addr(idex_rs2_addr),
        .idex_rd_addr(idex_rd_addr), .idex_alu_op(idex_alu_op),
        .idex_alu_src(idex_alu_src), .idex_mem_read(idex_mem_read),
        .idex_mem_write(idex_mem_write), .idex_unsigned_load(idex_unsigned_load),
        .idex_reg_write(idex_reg_write), .idex_mem_to_reg(idex_mem_to_reg),
        .idex_mask(idex_mask), .idex_illegal(idex_illegal),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    // Instruction words used below.
    localparam logic [31:0] I_ADD   = 32'h00228333; // add  x6,x5,x2
    localparam logic [31:0] I_ADDI  = 32'hFFF08513; // addi x10,x1,-1
    localparam logic [31:0] I_SW    = 32'h0020A423; // sw   x2,8(x1)
    localparam logic [31:0] I_AUIPC = 32'h12345297; // auipc x5,0x12345
    localparam logic [31:0] I_BEQ   = 32'h00028863; // beq  x5,x0,+16
    localparam logic [31:0] I_BNE   = 32'h00039463; // bne  x7,x0,+8
    localparam logic [31:0] I_JAL   = 32'h040000EF; // jal  x1,+0x40
    localparam logic [31:0] I_JALR  = 32'h004180E7; // jalr x1,4(x3)
    localparam logic [31:0] I_JALR0 = 32'h008000E7; // jalr x1,8(x0)
    localparam logic [31:0] I_BLT   = 32'h0062C863; // blt  x5,x6,+16
    localparam logic [31:0] I_BLTU  = 32'h0062E863; // bltu x5,x6,+16
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    typedef struct {
        string       nm;
        logic        v;
        logic [31:0] pc, inst, r1, r2;
        logic        e_rdy, e_redir;
        logic [31:0] e_rpc;
        logic        e_vld;
        logic [31:0] e_imm, e_r1;
        logic        e_rw, e_mw, e_ill;
    } vec_t;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic v, input logic [31:0] pc,
                                input logic [31:0] inst, input logic [31:0] r1,
                                input logic [31:0] r2, input logic rdy, input logic redir,
                                input logic [31:0] rpc, input logic vld,
                                input logic [31:0] imm, input logic rw, input logic mw,
                                input logic ill);
        vec_t t;
        t.nm = nm; t.v = v; t.pc = pc; t.inst = inst; t.r1 = r1; t.r2 = r2;
        t.e_rdy = rdy; t.e_redir = redir; t.e_rpc = rpc; t.e_vld = vld;
        t.e_imm = imm; t.e_r1 = vld ? r1 : 32'h0;
        t.e_rw = rw; t.e_mw = mw; t.e_ill = ill;
        return t;
    endfunction

    task automatic idle();
        if_valid = 1'b0; if_pc = '0; if_inst = '0;
        rs1_data_reg = '0; rs2_data_reg = '0;
        ex_rd_addr = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd_addr = '0; mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_fwd_data = '0;
        wb_rd_addr = '0; wb_reg_write = 1'b0; wb_fwd_data = '0;
        ex_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    task automatic drive_id(input logic [31:0] pc, input logic [31:0] inst);
        if_valid = 1'b1; if_pc = pc; if_inst = inst;
    endtask

    vec_t tbl [12];

    initial begin
        rst = 1'b1;
        idle();
        #12;
        chk("rst idex_valid", 32'(idex_valid), 32'h0);
        chk("rst idex_mask", 32'(idex_mask), 32'h2);
        chk("rst stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst redirect_valid", 32'(redirect_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //          name     v  pc        inst     r1            r2      rdy redir rpc      vld imm           rw mw ill
        tbl[0]  = mk("add",   1, 32'h010, I_ADD,   32'h11,       32'h22, 1, 0, 32'h0,    1, 32'h0,        1, 0, 0);
        tbl[1]  = mk("addi",  1, 32'h014, I_ADDI,  32'h7,        32'h0,  1, 0, 32'h0,    1, 32'hFFFFFFFF, 1, 0, 0);
        tbl[2]  = mk("sw",    1, 32'h018, I_SW,    32'h100,      32'h55, 1, 0, 32'h0,    1, 32'h8,        0, 1, 0);
        tbl[3]  = mk("auipc", 1, 32'h1000,I_AUIPC, 32'h0,        32'h0,  1, 0, 32'h0,    1, 32'h12346000, 1, 0, 0);
        tbl[4]  = mk("beq_nt",1, 32'h100, I_BEQ,   32'h1,        32'h0,  1, 0, 32'h0,    1, 32'h10,       0, 0, 0);
        tbl[5]  = mk("beq_t", 1, 32'h100, I_BEQ,   32'h0,        32'h0,  1, 1, 32'h110,  1, 32'h10,       0, 0, 0);
        tbl[6]  = mk("jal",   1, 32'h300, I_JAL,   32'h0,        32'h0,  1, 1, 32'h340,  1, 32'h304,      1, 0, 0);
        tbl[7]  = mk("jalr",  1, 32'h400, I_JALR,  32'h2003,     32'h0,  1, 1, 32'h2006, 1, 32'h404,      1, 0, 0);
        tbl[8]  = mk("illeg", 1, 32'h500, I_ILL,   32'h0,        32'h0,  1, 0, 32'h0,    1, 32'h0,        0, 0, 1);
        tbl[9]  = mk("blt_t", 1, 32'h600, I_BLT,   32'hFFFFFFFF, 32'h1,  1, 1, 32'h610,  1, 32'h10,       0, 0, 0);
        tbl[10] = mk("bltu_nt",1,32'h600, I_BLTU,  32'hFFFFFFFF, 32'h1,  1, 0, 32'h0,    1, 32'h10,       0, 0, 0);
        tbl[11] = mk("empty", 0, 32'h300, I_JAL,   32'h0,        32'h0,  1, 0, 32'h0,    0, 32'h0,        0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            idle();
            if_valid = tbl[i].v; if_pc = tbl[i].pc; if_inst = tbl[i].inst;
            rs1_data_reg = tbl[i].r1; rs2_data_reg = tbl[i].r2;
            #1;
            chk({tbl[i].nm, " id_ready"}, 32'(id_ready), 32'(tbl[i].e_rdy));
            chk({tbl[i].nm, " redirect_valid"}, 32'(redirect_valid), 32'(tbl[i].e_redir));
            if (tbl[i].e_redir) chk({tbl[i].nm, " redirect_pc"}, redirect_pc, tbl[i].e_rpc);
            @(posedge clk); #1;
            chk({tbl[i].nm, " idex_valid"}, 32'(idex_valid), 32'(tbl[i].e_vld));
            chk({tbl[i].nm, " idex_imm"}, idex_imm, tbl[i].e_imm);
            chk({tbl[i].nm, " idex_rs1_data"}, idex_rs1_data, tbl[i].e_r1);
            chk({tbl[i].nm, " idex_reg_write"}, 32'(idex_reg_write), 32'(tbl[i].e_rw));
            chk({tbl[i].nm, " idex_mem_write"}, 32'(idex_mem_write), 32'(tbl[i].e_mw));
            chk({tbl[i].nm, " idex_illegal"}, 32'(idex_illegal), 32'(tbl[i].e_ill));
        end

        // Load-use: lw x5 in EX, add x6,x5,x2 in ID.
        do_reset();
        @(negedge clk);
        drive_id(32'h20, I_ADD);
        ex_rd_addr = 5; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        #1 chk("lu id_ready", 32'(id_ready), 32'h0);
        @(posedge clk); #1;
        chk("lu bubble", 32'(idex_valid), 32'h0);
        chk("lu stall_cnt", 32'(stall_cnt), 32'h1);
        @(negedge clk);
        ex_rd_addr = 0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd_addr = 5; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
        #1 chk("lu2 id_ready", 32'(id_ready), 32'h1);
        @(posedge clk); #1;
        chk("lu2 idex_valid", 32'(idex_valid), 32'h1);
        chk("lu2 idex_rd_addr", 32'(idex_rd_addr), 32'h6);
        chk("lu2 stall_cnt", 32'(stall_cnt), 32'h1);

        // Load -> branch: two stall cycles, then operand from WB.
        do_reset();
        @(negedge clk);
        drive_id(32'h100, I_BEQ);
        rs1_data_reg = 32'hDEAD;
        ex_rd_addr = 5; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        #1 chk("lb c1 id_ready", 32'(id_ready), 32'h0);
        chk("lb c1 redirect", 32'(redirect_valid), 32'h0);
        @(posedge clk); #1 chk("lb c1 stall_cnt", 32'(stall_cnt), 32'h1);
        @(negedge clk);
        ex_rd_addr = 0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd_addr = 5; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
        #1 chk("lb c2 id_ready", 32'(id_ready), 32'h0);
        @(posedge clk); #1 chk("lb c2 stall_cnt", 32'(stall_cnt), 32'h2);
        @(negedge clk);
        mem_rd_addr = 0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
        wb_rd_addr = 5; wb_reg_write = 1'b1; wb_fwd_data = 32'h0;
        #1 chk("lb c3 redirect", 32'(redirect_valid), 32'h1);
        chk("lb c3 redirect_pc", redirect_pc, 32'h110);
        @(posedge clk); #1;
        chk("lb redirect_cnt", 32'(redirect_cnt), 32'h1);
        chk("lb idex_rs1_data", idex_rs1_data, 32'h0);
        chk("lb stall_cnt final", 32'(stall_cnt), 32'h2);

        // Forward priority: MEM beats WB; MEM load is not forwarded and stalls.
        @(negedge clk);
        idle();
        drive_id(32'h200, I_BNE);
        mem_rd_addr = 7; mem_reg_write = 1'b1; mem_fwd_data = 32'hAAAA;
        wb_rd_addr = 7; wb_reg_write = 1'b1; wb_fwd_data = 32'h5555;
        #1 chk("fp redirect", 32'(redirect_valid), 32'h1);
        chk("fp redirect_pc", redirect_pc, 32'h208);
        @(posedge clk); #1 chk("fp idex_rs1_data", idex_rs1_data, 32'hAAAA);
        @(negedge clk);
        mem_mem_read = 1'b1;
        #1 chk("fp load id_ready", 32'(id_ready), 32'h0);
        chk("fp load redirect", 32'(redirect_valid), 32'h0);

        // Back-pressure with a taken jal in ID.
        do_reset();
        @(negedge clk);
        drive_id(32'h14, I_ADDI);
        rs1_data_reg = 32'h7;
        @(posedge clk);
        @(negedge clk);
        drive_id(32'h300, I_JAL);
        ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp redirect", 32'(redirect_valid), 32'h0);
            @(posedge clk); #1 chk("bp idex_imm held", idex_imm, 32'hFFFFFFFF);
            @(negedge clk);
        end
        chk("bp stall_cnt", 32'(stall_cnt), 32'h0);
        ex_ready = 1'b1;
        #1 chk("bp release redirect", 32'(redirect_valid), 32'h1);
        chk("bp release redirect_pc", redirect_pc, 32'h340);
        @(posedge clk); #1;
        chk("bp idex_imm link", idex_imm, 32'h304);
        chk("bp redirect_cnt", 32'(redirect_cnt), 32'h1);
        @(negedge clk);
        if_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp redirect_cnt once", 32'(redirect_cnt), 32'h1);
        chk("bp flush bubble", 32'(idex_valid), 32'h0);

        // x0 source never stalls, even against rd = x0 producers.
        @(negedge clk);
        idle();
        drive_id(32'h40, I_JALR0);
        ex_rd_addr = 0; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        mem_rd_addr = 0; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
        #1 chk("x0 id_ready", 32'(id_ready), 32'h1);
        chk("x0 redirect", 32'(redirect_valid), 32'h1);
        chk("x0 redirect_pc", redirect_pc, 32'h8);

        // Reset mid-stall clears everything asynchronously.
        do_reset();
        @(negedge clk);
        drive_id(32'h20, I_ADD);
        ex_rd_addr = 5; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle();
        drive_id(32'h300, I_JAL);
        @(posedge clk);
        @(negedge clk);
        drive_id(32'h20, I_ADD);
        ex_rd_addr = 5; ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_ready = 1'b0;
        #1;
        chk("mr pre stall_cnt", 32'(stall_cnt), 32'h1);
        chk("mr pre idex_imm", idex_imm, 32'h304);
        rst = 1'b1;
        #1;
        chk("mr idex_valid", 32'(idex_valid), 32'h0);
        chk("mr idex_imm", idex_imm, 32'h0);
        chk("mr idex_mask", 32'(idex_mask), 32'h2);
        chk("mr stall_cnt", 32'(stall_cnt), 32'h0);
        chk("mr redirect_cnt", 32'(redirect_cnt), 32'h0);
        rst = 1'b0;

        // Saturation of the 4-bit stall counter.
        do_reset();
        @(negedge clk);
        drive_id(32'h20, I_ADD);
        ex_rd_addr = 5; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 14) chk("sat stall_cnt 14", 32'(stall_cnt), 32'd14);
        end
        chk("sat stall_cnt 20", 32'(stall_cnt), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
